// File: rtl/knight_anim_pkg.sv
// Shared types and constants for the knight animation sequencer.
// Optional feature macro used by knight_anim_ctrl: KNIGHT_WALK_CYCLE_EN.
package knight_anim_pkg;

    // Width of the status bus consumed by player_mapper.
    localparam int STATUS_W = 4;

    // Default sprite dimensions.
    localparam int SIZE_X_GROUND_DEF = 50;
    localparam int SIZE_X_AIR_DEF    = 45;
    localparam int SIZE_Y_DEF        = 64;

    // Encodings match the mapper's Player_Status values.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WALK = 2'd1,
        ST_JUMP = 2'd2,
        ST_FALL = 2'd3
    } anim_state_t;

    // Airborne states use the narrower sprite and skip the dwell rule.
    function automatic logic is_airborne(input anim_state_t s);
        return (s == ST_JUMP) || (s == ST_FALL);
    endfunction

endpackage

// File: rtl/knight_anim_ctrl_frame_tick_sync.sv
// frame_tick_sync: brings the vsync-rate frame_clk into the Clk domain and
// emits a one-cycle frame_tick per rising edge. After reset a low level must
// be observed before the next rise counts, so an edge in flight is dropped.
module frame_tick_sync (
    input  logic Clk,
    input  logic Reset_n,
    input  logic frame_clk,
    output logic frame_tick
);

    logic       meta_q;
    logic       sync_q;
    logic       prev_q;
    logic [1:0] fill_q;   // counts edges until sync_q holds a real sample
    logic       armed_q;  // set once a genuine low level has been seen
    logic       tick_q;

    // Synchronizer, arming logic and registered rising-edge detector.
    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            meta_q  <= 1'b0;
            sync_q  <= 1'b0;
            prev_q  <= 1'b0;
            fill_q  <= 2'd0;
            armed_q <= 1'b0;
            tick_q  <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments let every flop see the pre-edge
            // value of its neighbour, which is what makes this a shift chain.
            meta_q <= frame_clk;
            sync_q <= meta_q;
            prev_q <= sync_q;
            if (fill_q != 2'd2) begin
                fill_q <= fill_q + 2'd1;
            end
            if ((fill_q == 2'd2) && !sync_q) begin
                armed_q <= 1'b1;
            end
            tick_q <= armed_q & sync_q & ~prev_q;
        end
    end

    assign frame_tick = tick_q;

endmodule

// File: rtl/knight_anim_ctrl.sv
// knight_anim_ctrl: per-frame animation state machine for the player knight.
// Optional feature: define KNIGHT_WALK_CYCLE_EN to alternate the walk and idle
// sprites on each walk half-cycle.
module knight_anim_ctrl
    import knight_anim_pkg::*;
#(
    parameter int SIZE_X_GROUND = SIZE_X_GROUND_DEF,
    parameter int SIZE_X_AIR    = SIZE_X_AIR_DEF,
    parameter int SIZE_Y        = SIZE_Y_DEF,
    parameter int MIN_DWELL     = 4,
    parameter int WALK_PERIOD   = 6
) (
    input  logic                Clk,
    input  logic                Reset_n,
    input  logic                frame_clk,
    input  logic                key_left,
    input  logic                key_right,
    input  logic                on_ground,
    input  logic [9:0]          vel_y,
    output logic [STATUS_W-1:0] Player_Status,
    output logic                Inverse,
    output logic [9:0]          Player_SizeX,
    output logic [9:0]          Player_SizeY,
    output logic                frame_tick,
    output logic                walk_phase
);

    localparam int DW = (MIN_DWELL > 1) ? $clog2(MIN_DWELL) : 1;
    localparam int WW = (WALK_PERIOD > 1) ? $clog2(WALK_PERIOD) : 1;
    localparam logic [DW-1:0] DWELL_MAX = DW'(MIN_DWELL - 1);
    localparam logic [WW-1:0] WALK_MAX  = WW'(WALK_PERIOD - 1);

    anim_state_t         state_q,      state_d;
    logic [DW-1:0]       dwell_q,      dwell_d;
    logic [WW-1:0]       walk_cnt_q,   walk_cnt_d;
    logic                walk_phase_q, walk_phase_d;
    logic                inverse_q,    inverse_d;
    logic [STATUS_W-1:0] status_q,     status_d;
    logic [9:0]          size_x_q,     size_x_d;
    logic                want_walk;
    anim_state_t         ground_target;

    frame_tick_sync u_frame_tick_sync (
        .Clk        (Clk),
        .Reset_n    (Reset_n),
        .frame_clk  (frame_clk),
        .frame_tick (frame_tick)
    );

    // Next-state, counters and registered-output values; only a tick moves them.
    always_comb begin
        // NOTE: every variable gets a default up front so no path leaves it
        // unassigned, which would otherwise infer a latch.
        state_d       = state_q;
        dwell_d       = dwell_q;
        walk_cnt_d    = walk_cnt_q;
        walk_phase_d  = walk_phase_q;
        inverse_d     = inverse_q;
        want_walk     = key_left ^ key_right;
        ground_target = want_walk ? ST_WALK : ST_IDLE;

        if (frame_tick) begin
            if (!on_ground) begin
                state_d = ($signed(vel_y) < 10'sd0) ? ST_JUMP : ST_FALL;
            end else if (is_airborne(state_q) || (dwell_q >= DWELL_MAX)) begin
                state_d = ground_target;
            end

            if (state_d != state_q) begin
                dwell_d = '0;
            end else if (dwell_q < DWELL_MAX) begin
                dwell_d = dwell_q + 1'b1;
            end

            if (key_left && !key_right) begin
                inverse_d = 1'b1;
            end else if (key_right && !key_left) begin
                inverse_d = 1'b0;
            end

            if ((state_d != ST_WALK) || (state_q != ST_WALK)) begin
                walk_cnt_d   = '0;
                walk_phase_d = 1'b0;
            end else if (walk_cnt_q == WALK_MAX) begin
                walk_cnt_d   = '0;
                walk_phase_d = ~walk_phase_q;
            end else begin
                walk_cnt_d = walk_cnt_q + 1'b1;
            end
        end

`ifdef KNIGHT_WALK_CYCLE_EN
        if ((state_d == ST_WALK) && walk_phase_d) begin
            status_d = STATUS_W'(ST_IDLE);
        end else begin
            status_d = STATUS_W'(state_d);
        end
`else
        status_d = STATUS_W'(state_d);
`endif

        size_x_d = is_airborne(state_d) ? 10'(SIZE_X_AIR) : 10'(SIZE_X_GROUND);
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            state_q      <= ST_IDLE;
            dwell_q      <= '0;
            walk_cnt_q   <= '0;
            walk_phase_q <= 1'b0;
            inverse_q    <= 1'b0;
            status_q     <= '0;
            size_x_q     <= 10'(SIZE_X_GROUND);
        end else begin
            state_q      <= state_d;
            dwell_q      <= dwell_d;
            walk_cnt_q   <= walk_cnt_d;
            walk_phase_q <= walk_phase_d;
            inverse_q    <= inverse_d;
            status_q     <= status_d;
            size_x_q     <= size_x_d;
        end
    end

    assign Player_Status = status_q;
    assign Inverse       = inverse_q;
    assign Player_SizeX  = size_x_q;
    assign Player_SizeY  = 10'(SIZE_Y);
    assign walk_phase    = walk_phase_q;

endmodule

// File: tb/tb_knight_anim_ctrl.sv
// Self-checking bench for knight_anim_ctrl: directed frames push expected
// outputs into a scoreboard; a monitor compares after each frame_tick.
module tb_knight_anim_ctrl;

`ifdef KNIGHT_WALK_CYCLE_EN
    localparam bit WALK_CYCLE = 1'b1;
`else
    localparam bit WALK_CYCLE = 1'b0;
`endif

    logic       Clk = 1'b0;
    logic       Reset_n = 1'b0;
    logic       frame_clk = 1'b0;
    logic       key_left = 1'b0;
    logic       key_right = 1'b0;
    logic       on_ground = 1'b1;
    logic [9:0] vel_y = 10'd0;
    logic [3:0] Player_Status;
    logic       Inverse;
    logic [9:0] Player_SizeX;
    logic [9:0] Player_SizeY;
    logic       frame_tick;
    logic       walk_phase;

    typedef struct {
        logic [3:0] status;
        logic       inv;
        logic [9:0] sx;
        logic       phase;
    } exp_t;

    exp_t sb_q[$];
    int   n_vec = 0;
    int   n_err = 0;
    int   n_pop = 0;

    knight_anim_ctrl dut (
        .Clk           (Clk),
        .Reset_n       (Reset_n),
        .frame_clk     (frame_clk),
        .key_left      (key_left),
        .key_right     (key_right),
        .on_ground     (on_ground),
        .vel_y         (vel_y),
        .Player_Status (Player_Status),
        .Inverse       (Inverse),
        .Player_SizeX  (Player_SizeX),
        .Player_SizeY  (Player_SizeY),
        .frame_tick    (frame_tick),
        .walk_phase    (walk_phase)
    );

    always #5 Clk = ~Clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Expected status while in WALK for a given walk phase.
    function automatic logic [3:0] walk_status(input bit ph);
        return (WALK_CYCLE && ph) ? 4'd0 : 4'd1;
    endfunction

    // Monitor: outputs settle one cycle after a frame_tick; compare then.
    initial begin
        bit   pending;
        exp_t e;
        pending = 1'b0;
        forever begin
            @(negedge Clk);
            if (!Reset_n) begin
                pending = 1'b0;
            end else begin
                if (pending) begin
                    if (sb_q.size() == 0) begin
                        check("unexpected_update", 32'd1, 32'd0);
                    end else begin
                        e = sb_q.pop_front();
                        n_pop++;
                        check($sformatf("status[%0d]", n_pop), Player_Status, e.status);
                        check($sformatf("inverse[%0d]", n_pop), Inverse, e.inv);
                        check($sformatf("sizex[%0d]", n_pop), Player_SizeX, e.sx);
                        check($sformatf("sizey[%0d]", n_pop), Player_SizeY, 32'd64);
                        check($sformatf("walk_phase[%0d]", n_pop), walk_phase, e.phase);
                    end
                end
                pending = frame_tick;
            end
        end
    end

    // One frame: set inputs, queue the expectation, pulse frame_clk and
    // check the tick latency and width.
    task automatic frame(input bit l, input bit r, input bit g, input logic [9:0] v,
                         input logic [3:0] st, input bit inv, input logic [9:0] sx,
                         input bit ph);
        int   seen;
        exp_t e;
        @(negedge Clk);
        key_left  = l;
        key_right = r;
        on_ground = g;
        vel_y     = v;
        e = '{status: st, inv: inv, sx: sx, phase: ph};
        sb_q.push_back(e);
        frame_clk = 1'b1;
        seen = 0;
        for (int i = 1; i <= 10 && seen == 0; i++) begin
            @(posedge Clk);
            #1;
            if (frame_tick) seen = i;
        end
        check("tick_latency", seen, 32'd3);
        if (seen != 0) begin
            @(posedge Clk);
            #1;
            check("tick_width", frame_tick, 32'd0);
        end
        @(negedge Clk);
        frame_clk = 1'b0;
        repeat (4) @(negedge Clk);
    endtask

    task automatic do_reset();
        @(negedge Clk);
        Reset_n = 1'b0;
        repeat (2) @(negedge Clk);
        Reset_n = 1'b1;
        repeat (3) @(negedge Clk);
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_status"}, Player_Status, 32'd0);
        check({tag, "_inverse"}, Inverse, 32'd0);
        check({tag, "_sizex"}, Player_SizeX, 32'd50);
        check({tag, "_sizey"}, Player_SizeY, 32'd64);
        check({tag, "_tick"}, frame_tick, 32'd0);
        check({tag, "_phase"}, walk_phase, 32'd0);
    endtask

    // Watchdog so the run always ends.
    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int seen;
        do_reset();
        check_reset_values("reset");

        // Idle with no keys.
        repeat (3) frame(0, 0, 1, 10'd0, 4'd0, 0, 10'd50, 0);

        // Fresh reset, then left held: dwell holds IDLE for three ticks.
        do_reset();
        repeat (3) frame(1, 0, 1, 10'd0, 4'd0, 1, 10'd50, 0);
        frame(1, 0, 1, 10'd0, 4'd1, 1, 10'd50, 0);

        // Airborne overrides dwell; landing with right held walks at once.
        frame(1, 0, 0, 10'h3FB, 4'd2, 1, 10'd45, 0);
        frame(1, 0, 0, 10'd0,   4'd3, 1, 10'd45, 0);
        frame(0, 1, 1, 10'd0,   4'd1, 0, 10'd50, 0);

        // Walk cycle: tick 0 was the landing tick above.
        for (int t = 1; t <= 13; t++) begin
            bit ph;
            ph = (t >= 6) && (t <= 11);
            frame(0, 1, 1, 10'd0, walk_status(ph), 0, 10'd50, ph);
        end

        // Both keys with dwell already met: IDLE, facing held.
        frame(1, 1, 1, 10'd0, 4'd0, 0, 10'd50, 0);
        repeat (3) frame(1, 0, 1, 10'd0, 4'd0, 1, 10'd50, 0);
        frame(1, 0, 1, 10'd0, 4'd1, 1, 10'd50, 0);
        // Both keys right after entering WALK: hold until dwell is met.
        repeat (3) frame(1, 1, 1, 10'd0, 4'd1, 1, 10'd50, 0);
        frame(1, 1, 1, 10'd0, 4'd0, 1, 10'd50, 0);

        // Into FALL, then reset one cycle after frame_clk rises.
        frame(0, 0, 0, 10'd3, 4'd3, 1, 10'd45, 0);
        @(negedge Clk);
        frame_clk = 1'b1;
        @(posedge Clk);
        @(negedge Clk);
        Reset_n = 1'b0;
        @(posedge Clk);
        #1;
        check_reset_values("midfall_reset");
        @(negedge Clk);
        Reset_n = 1'b1;
        seen = 0;
        repeat (10) begin
            @(posedge Clk);
            #1;
            if (frame_tick) seen++;
        end
        check("no_tick_after_reset", seen, 32'd0);
        @(negedge Clk);
        frame_clk = 1'b0;
        repeat (4) @(negedge Clk);

        // Signed velocity boundaries, then land idle.
        frame(0, 0, 0, 10'h3FF, 4'd2, 0, 10'd45, 0);
        frame(0, 0, 0, 10'h1FF, 4'd3, 0, 10'd45, 0);
        frame(0, 0, 1, 10'd0,   4'd0, 0, 10'd50, 0);

        repeat (4) @(negedge Clk);
        check("scoreboard_drained", sb_q.size(), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
